// File: rtl/autoconfig_pkg.sv
// autoconfig_pkg: register offsets, er_Type constants, size codes and FSM states for the Zorro II AutoConfig chain
package autoconfig_pkg;

   // Offsets are A6..A1, i.e. the byte offset within $E8xxxx shifted right by one
   localparam logic [5:0] OFF_ER_TYPE  = 6'h00;
   localparam logic [5:0] OFF_ER_SIZE  = 6'h01;
   localparam logic [5:0] OFF_PROD_HI  = 6'h02;
   localparam logic [5:0] OFF_PROD_LO  = 6'h03;
   localparam logic [5:0] OFF_ER_FLAGS = 6'h04;
   localparam logic [5:0] OFF_MFG      = 6'h08;
   localparam logic [5:0] OFF_SERIAL   = 6'h0C;
   localparam logic [5:0] OFF_ROM      = 6'h14;
   localparam logic [5:0] OFF_CTRL_0   = 6'h20;
   localparam logic [5:0] OFF_CTRL_1   = 6'h21;
   localparam logic [5:0] OFF_BASE_HI  = 6'h24;
   localparam logic [5:0] OFF_BASE_LO  = 6'h25;
   localparam logic [5:0] OFF_SHUTUP   = 6'h26;

   localparam logic [1:0] ERT_ZORRO_II = 2'b11;
   localparam logic [3:0] ER_FLAGS     = 4'b1100;

   typedef enum logic [2:0] {
      SIZE_8M   = 3'b000,
      SIZE_64K  = 3'b001,
      SIZE_128K = 3'b010,
      SIZE_256K = 3'b011,
      SIZE_512K = 3'b100,
      SIZE_1M   = 3'b101,
      SIZE_2M   = 3'b110,
      SIZE_4M   = 3'b111
   } size_code_t;

   typedef enum logic [1:0] {ST_SELECT, ST_ACTIVE, ST_WAIT_AS, ST_DONE} state_t;

   function automatic logic [3:0] nib16(input logic [15:0] v, input logic [1:0] k);
      return v[15-4*k -: 4];
   endfunction

   function automatic logic [3:0] nib32(input logic [31:0] v, input logic [2:0] k);
      return v[31-4*k -: 4];
   endfunction

endpackage

// File: rtl/autoconfig_nibble_rom.sv
// autoconfig_nibble_rom: combinational AutoConfig register nibble for the board selected by cur
module autoconfig_nibble_rom
   import autoconfig_pkg::*;
#(
   parameter int                      NUM_BOARDS  = 2,
   parameter int                      CW          = 2,
   parameter logic [15:0]             MFG_ID      = 16'h082C,
   parameter logic [31:0]             SERIAL      = 32'h0,
   parameter logic [8*NUM_BOARDS-1:0]  PROD_IDS    = {8'd6, 8'd8},
   parameter logic [3*NUM_BOARDS-1:0]  SIZE_CODES  = {3'b001, 3'b000},
   parameter logic [NUM_BOARDS-1:0]    MEMLIST     = 2'b01,
   parameter logic [NUM_BOARDS-1:0]    ROM_VALID   = 2'b10,
   parameter logic [16*NUM_BOARDS-1:0] ROM_OFFSETS = {16'h0001, 16'h0}
)(
   input  logic [5:0]    a_low,
   input  logic [CW-1:0] cur,
   output logic [3:0]    nibble
);

   logic [7:0]  prod;
   logic [2:0]  size;
   logic        ml;
   logic        rv;
   logic [15:0] rom;
   logic [2:0]  sk;

   // Pick the current board's parameter slice
   always_comb begin
      prod = '0;
      size = '0;
      ml   = 1'b0;
      rv   = 1'b0;
      rom  = '0;
      for (int i = 0; i < NUM_BOARDS; i++)
         if (cur == CW'(i)) begin
            prod = PROD_IDS[8*i +: 8];
            size = SIZE_CODES[3*i +: 3];
            ml   = MEMLIST[i];
            rv   = ROM_VALID[i];
            rom  = ROM_OFFSETS[16*i +: 16];
         end
   end

   // Serial nibbles span $0C..$13, so the index is taken modulo 8
   assign sk = a_low[2:0] - OFF_SERIAL[2:0];

   // Everything except er_Type/size and the control pair reads back inverted
   always_comb begin
      nibble = (a_low == OFF_ER_TYPE)                     ? {ERT_ZORRO_II, ml, rv} :
               (a_low == OFF_ER_SIZE)                     ? {1'b0, size} :
               (a_low == OFF_PROD_HI)                     ? ~prod[7:4] :
               (a_low == OFF_PROD_LO)                     ? ~prod[3:0] :
               (a_low == OFF_ER_FLAGS)                    ? ~ER_FLAGS :
               (a_low[5:2] == OFF_MFG[5:2])               ? ~nib16(MFG_ID, a_low[1:0]) :
               (a_low >= OFF_SERIAL && a_low < OFF_ROM)   ? ~nib32(SERIAL, sk) :
               (a_low[5:2] == OFF_ROM[5:2])               ? (rv ? ~nib16(rom, a_low[1:0]) : 4'hF) :
               (a_low == OFF_CTRL_0 || a_low == OFF_CTRL_1) ? 4'h0 : 4'hF;
   end

endmodule

// File: rtl/autoconfig_zii_chain.sv
// autoconfig_zii_chain: presents NUM_BOARDS logical Zorro II boards in turn at $E8xxxx and captures their bases
module autoconfig_zii_chain
   import autoconfig_pkg::*;
#(
   parameter int                      NUM_BOARDS  = 2,
   parameter logic [15:0]             MFG_ID      = 16'h082C,
   parameter logic [31:0]             SERIAL      = 32'h0,
   parameter logic [8*NUM_BOARDS-1:0]  PROD_IDS    = {8'd6, 8'd8},
   parameter logic [3*NUM_BOARDS-1:0]  SIZE_CODES  = {3'b001, 3'b000},
   parameter logic [NUM_BOARDS-1:0]    MEMLIST     = 2'b01,
   parameter logic [NUM_BOARDS-1:0]    ROM_VALID   = 2'b10,
   parameter logic [16*NUM_BOARDS-1:0] ROM_OFFSETS = {16'h0001, 16'h0}
)(
   input  logic                      C7M,
   input  logic                      RESET_n,
   input  logic                      CFGIN_n,
   input  logic                      AS_CPU_n,
   input  logic                      DS_n,
   input  logic                      RW_n,
   input  logic [7:0]                A_HIGH,
   input  logic [5:0]                A_LOW,
   input  logic [NUM_BOARDS-1:0]     BOARD_EN,
   input  logic [15:0]               data_in,
   output logic [15:0]               data_out,
   output logic                      data_oe,
   output logic [8*NUM_BOARDS-1:0]   BASE,
   output logic [NUM_BOARDS-1:0]     CONFIGURED_n,
   output logic                      CFGOUT_n
);

   localparam int CW = $clog2(NUM_BOARDS + 1);

   state_t        state;
   logic [CW-1:0] cur;
   logic [CW-1:0] sel_idx;
   logic          sel_found;
   logic [3:0]    lo_stage;
   logic [3:0]    nib_q;
   logic [3:0]    rom_nib;
   logic          as_meta;
   logic          as_s;
   logic          as_d;
   logic          access;
   logic          rd;
   logic          wr;
   logic          unused_data;

   assign unused_data = ^data_in[11:0];
   assign access      = !CFGIN_n && state == ST_ACTIVE && A_HIGH == 8'hE8 && !AS_CPU_n;
   assign rd          = access && !DS_n && RW_n;
   assign wr          = access && !DS_n && !RW_n;
   assign data_oe     = rd;
   assign data_out    = {nib_q, 12'd0};

   autoconfig_nibble_rom #(
      .NUM_BOARDS (NUM_BOARDS),
      .CW         (CW),
      .MFG_ID     (MFG_ID),
      .SERIAL     (SERIAL),
      .PROD_IDS   (PROD_IDS),
      .SIZE_CODES (SIZE_CODES),
      .MEMLIST    (MEMLIST),
      .ROM_VALID  (ROM_VALID),
      .ROM_OFFSETS(ROM_OFFSETS)
   ) u_rom (
      .a_low (A_LOW),
      .cur   (cur),
      .nibble(rom_nib)
   );

   // Lowest enabled board at or above cur; descending scan leaves the lowest hit
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = cur;
      for (int i = NUM_BOARDS - 1; i >= 0; i--)
         if (CW'(i) >= cur && BOARD_EN[i]) begin
            sel_found = 1'b1;
            sel_idx   = CW'(i);
         end
   end

   // Two-flop synchroniser plus a delayed copy for AS rising-edge detection
   always_ff @(posedge C7M or negedge RESET_n) begin
      if (!RESET_n) begin
         as_meta <= 1'b1;
         as_s    <= 1'b1;
         as_d    <= 1'b1;
      end else begin
         as_meta <= AS_CPU_n;
         as_s    <= as_meta;
         as_d    <= as_s;
      end
   end

   // Read nibble is captured while a read is in progress and held afterwards
   always_ff @(posedge C7M or negedge RESET_n) begin
      if (!RESET_n)
         nib_q <= 4'hF;
      else if (rd)
         nib_q <= rom_nib;
   end

   // Chain sequencer: select board, answer, wait for end of strobe, advance
   always_ff @(posedge C7M or negedge RESET_n) begin
      if (!RESET_n) begin
         state        <= ST_SELECT;
         cur          <= '0;
         lo_stage     <= 4'h0;
         BASE         <= '0;
         CONFIGURED_n <= '1;
         CFGOUT_n     <= 1'b1;
      end else begin
         case (state)
            ST_SELECT: begin
               cur      <= sel_idx;
               state    <= sel_found ? ST_ACTIVE : ST_DONE;
               CFGOUT_n <= sel_found;
            end
            ST_ACTIVE: begin
               if (wr && A_LOW == OFF_BASE_LO)
                  lo_stage <= data_in[15:12];
               if (wr && A_LOW == OFF_BASE_HI) begin
                  for (int i = 0; i < NUM_BOARDS; i++)
                     if (cur == CW'(i)) begin
                        BASE[8*i +: 8]  <= {data_in[15:12], lo_stage};
                        CONFIGURED_n[i] <= 1'b0;
                     end
                  state <= ST_WAIT_AS;
               end
               if (wr && A_LOW == OFF_SHUTUP)
                  state <= ST_WAIT_AS;
            end
            ST_WAIT_AS: begin
               if (as_s && !as_d) begin
                  cur      <= cur + 1'b1;
                  lo_stage <= 4'h0;
                  state    <= ST_SELECT;
               end
            end
            ST_DONE: CFGOUT_n <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_autoconfig_zii_chain.sv
// tb_autoconfig_zii_chain: scoreboard bench for the two-board AutoConfig chain
module tb_autoconfig_zii_chain;

   logic        C7M = 1'b0;
   logic        RESET_n = 1'b1;
   logic        CFGIN_n = 1'b0;
   logic        AS_CPU_n = 1'b1;
   logic        DS_n = 1'b1;
   logic        RW_n = 1'b1;
   logic [7:0]  A_HIGH = 8'h00;
   logic [5:0]  A_LOW = 6'h00;
   logic [1:0]  BOARD_EN = 2'b11;
   logic [15:0] data_in = 16'h0000;
   logic [15:0] data_out;
   logic        data_oe;
   logic [15:0] BASE;
   logic [1:0]  CONFIGURED_n;
   logic        CFGOUT_n;

   int         vectors = 0;
   int         miscompares = 0;
   logic [3:0] sb[$];
   logic       oe_seen;
   int         oe_bad = 0;
   bit         mon = 1'b0;

   always #5 C7M = ~C7M;

   autoconfig_zii_chain dut (
      .C7M         (C7M),
      .RESET_n     (RESET_n),
      .CFGIN_n     (CFGIN_n),
      .AS_CPU_n    (AS_CPU_n),
      .DS_n        (DS_n),
      .RW_n        (RW_n),
      .A_HIGH      (A_HIGH),
      .A_LOW       (A_LOW),
      .BOARD_EN    (BOARD_EN),
      .data_in     (data_in),
      .data_out    (data_out),
      .data_oe     (data_oe),
      .BASE        (BASE),
      .CONFIGURED_n(CONFIGURED_n),
      .CFGOUT_n    (CFGOUT_n)
   );

   always @(negedge C7M) if (mon && data_oe) oe_bad++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic strobe(input logic rw, input logic [7:0] off, input logic [15:0] d);
      @(negedge C7M);
      A_HIGH = 8'hE8; A_LOW = off[6:1]; RW_n = rw; data_in = d;
      AS_CPU_n = 1'b0; DS_n = 1'b0; oe_seen = 1'b0;
      repeat (3) begin
         @(negedge C7M);
         oe_seen |= data_oe;
      end
   endtask

   task automatic release_bus(input int n);
      AS_CPU_n = 1'b1; DS_n = 1'b1; RW_n = 1'b1;
      repeat (n) @(negedge C7M);
   endtask

   task automatic rd(input logic [7:0] off, input logic [3:0] exp, input logic oe_exp);
      sb.push_back(exp);
      strobe(1'b1, off, 16'h0);
      release_bus(1);
      check($sformatf("oe@%02h", off), oe_seen, oe_exp);
      check($sformatf("rd@%02h", off), data_out[15:12], sb.pop_front());
   endtask

   task automatic wr(input logic [7:0] off, input logic [15:0] d, input int n);
      strobe(1'b0, off, d);
      release_bus(n);
   endtask

   task automatic apply_reset(input logic [1:0] en);
      @(negedge C7M);
      RESET_n = 1'b0; BOARD_EN = en; CFGIN_n = 1'b0;
      AS_CPU_n = 1'b1; DS_n = 1'b1; RW_n = 1'b1;
      repeat (2) @(negedge C7M);
      RESET_n = 1'b1;
      repeat (2) @(negedge C7M);
   endtask

   task automatic wait_cfgout(input int budget, input string tag);
      int k = 0;
      while (CFGOUT_n !== 1'b0 && k < budget) begin
         @(negedge C7M);
         k++;
      end
      check(tag, CFGOUT_n, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // reset values
      @(negedge C7M);
      RESET_n = 1'b0;
      repeat (2) @(negedge C7M);
      check("rst_dout", data_out, 16'hF000);
      check("rst_base", BASE, 16'h0000);
      check("rst_cfgd", CONFIGURED_n, 2'b11);
      check("rst_cfgout", CFGOUT_n, 1'b1);
      check("rst_oe", data_oe, 1'b0);
      RESET_n = 1'b1;
      repeat (2) @(negedge C7M);

      // board 0 register map
      rd(8'h00, 4'hE, 1'b1);
      check("dout_lo", data_out[11:0], 12'h000);
      rd(8'h02, 4'h0, 1'b1);
      rd(8'h04, 4'hF, 1'b1);
      rd(8'h06, 4'h7, 1'b1);
      rd(8'h08, 4'h3, 1'b1);
      rd(8'h0A, 4'hF, 1'b1);
      rd(8'h10, 4'hF, 1'b1);
      rd(8'h12, 4'h7, 1'b1);
      rd(8'h14, 4'hD, 1'b1);
      rd(8'h16, 4'h3, 1'b1);
      rd(8'h18, 4'hF, 1'b1);
      rd(8'h40, 4'h0, 1'b1);
      rd(8'h42, 4'h0, 1'b1);
      rd(8'h2E, 4'hF, 1'b1);
      rd(8'h4A, 4'hF, 1'b1);

      // configure board 0 at $20
      wr(8'h4A, 16'h0000, 1);
      wr(8'h48, 16'h2000, 6);
      check("b0_base", BASE[7:0], 8'h20);
      check("b0_cfgd", CONFIGURED_n, 2'b10);
      check("b0_cfgout", CFGOUT_n, 1'b1);
      rd(8'h00, 4'hD, 1'b1);
      rd(8'h2E, 4'hE, 1'b1);
      rd(8'h2C, 4'hF, 1'b1);
      rd(8'h02, 4'h1, 1'b1);
      CFGIN_n = 1'b1;
      rd(8'h00, 4'h1, 1'b0);
      CFGIN_n = 1'b0;

      // configure board 1 at $9E, chain completes
      wr(8'h4A, 16'hE000, 1);
      wr(8'h48, 16'h9000, 2);
      wait_cfgout(3, "b1_cfgout");
      check("b1_base", BASE[15:8], 8'h9E);
      check("b1_base0", BASE[7:0], 8'h20);
      check("b1_cfgd", CONFIGURED_n, 2'b00);
      rd(8'h00, 4'h1, 1'b0);

      // shut up board 0
      apply_reset(2'b11);
      wr(8'h4C, 16'h0000, 6);
      check("su_cfgd", CONFIGURED_n, 2'b11);
      check("su_cfgout", CFGOUT_n, 1'b1);
      check("su_base", BASE, 16'h0000);
      rd(8'h00, 4'hD, 1'b1);

      // no boards enabled
      @(negedge C7M);
      RESET_n = 1'b0; BOARD_EN = 2'b00; oe_bad = 0; mon = 1'b1;
      repeat (2) @(negedge C7M);
      RESET_n = 1'b1;
      wait_cfgout(2, "none_cfgout");
      rd(8'h00, 4'hF, 1'b0);
      mon = 1'b0;
      check("none_oe", oe_bad, 0);
      check("none_cfgd", CONFIGURED_n, 2'b11);

      // only board 1 enabled
      apply_reset(2'b10);
      rd(8'h00, 4'hD, 1'b1);
      check("skip_cfgout", CFGOUT_n, 1'b1);

      // reset between base write and end of strobe
      apply_reset(2'b11);
      wr(8'h4A, 16'h5000, 1);
      strobe(1'b0, 8'h48, 16'h3000);
      check("mid_base", BASE[7:0], 8'h35);
      check("mid_cfgd", CONFIGURED_n, 2'b10);
      RESET_n = 1'b0;
      #1;
      check("mid_rst_base", BASE, 16'h0000);
      check("mid_rst_cfgd", CONFIGURED_n, 2'b11);
      check("mid_rst_cfgout", CFGOUT_n, 1'b1);
      release_bus(1);
      RESET_n = 1'b1;
      repeat (2) @(negedge C7M);
      rd(8'h00, 4'hE, 1'b1);
      wr(8'h48, 16'h4000, 6);
      check("nolo_base", BASE[7:0], 8'h40);
      check("nolo_cfgd", CONFIGURED_n, 2'b10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
